// File: rtl/sa_pkg.sv
// Shared defaults, FSM state type and saturation helper for sa_result_drain.
// Optional output saturation is enabled by defining SA_DRAIN_SAT8_EN.
package sa_pkg;

  localparam int SA_WIDTH = 8;
  localparam int SA_N     = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_CLEAR
  } sa_state_e;

  // Returns {above_max, below_min} for v against signed w-bit range.
  function automatic logic [1:0] sa_sat(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return {(v > hi), (v < lo)};
  endfunction

endpackage

// File: rtl/sa_sat_narrow.sv
// Clamps a signed 2*WIDTH element into signed WIDTH range.
// Used by sa_result_drain only when SA_DRAIN_SAT8_EN is defined.
module sa_sat_narrow
  import sa_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH
) (
  input  logic [2*WIDTH-1:0] i_val,
  output logic [2*WIDTH-1:0] o_val
);

  logic signed [63:0] w_wide;
  logic [1:0]         w_flag;

  assign w_wide = {{(64-2*WIDTH){i_val[2*WIDTH-1]}}, i_val};
  assign w_flag = sa_sat(w_wide, WIDTH);

  always_comb begin
    o_val = i_val;
    unique case (1'b1)
      w_flag[1]: o_val = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
      w_flag[0]: o_val = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
      default:   o_val = i_val;
    endcase
  end

endmodule

// File: rtl/sa_result_drain.sv
// Captures both systolic result matrices on done and streams them out.
// Define SA_DRAIN_SAT8_EN to saturate out_data to signed WIDTH range.
module sa_result_drain
  import sa_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH,
  parameter int N     = SA_N
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      done,
  input  logic [N*N*2*WIDTH-1:0]    res1_flat,
  input  logic [N*N*2*WIDTH-1:0]    res2_flat,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*WIDTH-1:0]        out_data,
  output logic                      out_mat,
  output logic [$clog2(N)-1:0]      out_row,
  output logic [$clog2(N)-1:0]      out_col,
  output logic                      out_last,
  output logic                      busy,
  output logic                      acc_clear,
  output logic                      overrun
);

  localparam int EW = 2 * WIDTH;
  localparam int NE = N * N;
  localparam int RW = $clog2(N);
  localparam int IW = $clog2(2 * NE);

  sa_state_e      r_state;
  sa_state_e      w_next;
  logic [IW-1:0]  r_idx;
  logic [EW-1:0]  r_buf [2*NE];
  logic           r_ovr;

  logic           w_cap;
  logic           w_xfer;
  logic           w_last;
  logic           w_mat;
  logic [IW-1:0]  w_elem;
  logic [EW-1:0]  w_raw;
  logic [EW-1:0]  w_data;

  assign w_cap  = (r_state == ST_IDLE) && done;
  assign w_xfer = out_valid && out_ready;
  assign w_last = (r_idx == IW'(2*NE-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (done && (r_state != ST_IDLE))
        r_ovr <= 1'b1;
      if (w_cap || (w_xfer && w_last))
        r_idx <= '0;
      else if (w_xfer)
        r_idx <= r_idx + IW'(1);
    end
  end

  // Snapshot buffer; no reset needed, it is only read in STREAM.
  always_ff @(posedge clk) begin
    if (w_cap && !reset) begin
      for (int k = 0; k < NE; k++) begin
        r_buf[k]      <= res1_flat[EW*k +: EW];
        r_buf[NE + k] <= res2_flat[EW*k +: EW];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (done) w_next = ST_STREAM;
      ST_STREAM: if (w_xfer && w_last) w_next = ST_CLEAR;
      ST_CLEAR:  w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  assign w_mat  = (r_idx >= IW'(NE));
  assign w_elem = w_mat ? (r_idx - IW'(NE)) : r_idx;
  assign w_raw  = r_buf[r_idx];

`ifdef SA_DRAIN_SAT8_EN
  sa_sat_narrow #(
    .WIDTH (WIDTH)
  ) u_sat (
    .i_val (w_raw),
    .o_val (w_data)
  );
`else
  assign w_data = w_raw;
`endif

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_mat   = 1'b0;
    out_row   = '0;
    out_col   = '0;
    out_last  = 1'b0;
    busy      = (r_state != ST_IDLE);
    acc_clear = (r_state == ST_CLEAR);
    overrun   = r_ovr;
    if (r_state == ST_STREAM) begin
      out_valid = 1'b1;
      out_data  = w_data;
      out_mat   = w_mat;
      out_row   = RW'(w_elem / IW'(N));
      out_col   = RW'(w_elem % IW'(N));
      out_last  = w_last;
    end
  end

endmodule

// File: tb/tb_sa_result_drain.sv
// Scoreboard bench for sa_result_drain (default N=4, WIDTH=8).
// Honours SA_DRAIN_SAT8_EN when computing expected element values.
module tb_sa_result_drain;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int EW = 2 * W;
  localparam int NE = N * N;
  localparam int RW = 2;

  typedef struct packed {
    logic [EW-1:0] data;
    logic          mat;
    logic [RW-1:0] row;
    logic [RW-1:0] col;
    logic          last;
  } beat_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            done;
  logic [NE*EW-1:0] res1_flat;
  logic [NE*EW-1:0] res2_flat;
  logic            out_valid;
  logic            out_ready;
  logic [EW-1:0]   out_data;
  logic            out_mat;
  logic [RW-1:0]   out_row;
  logic [RW-1:0]   out_col;
  logic            out_last;
  logic            busy;
  logic            acc_clear;
  logic            overrun;

  beat_t q[$];
  int    checks   = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  sa_result_drain #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .done      (done),
    .res1_flat (res1_flat),
    .res2_flat (res2_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mat   (out_mat),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .busy      (busy),
    .acc_clear (acc_clear),
    .overrun   (overrun)
  );

  function automatic logic [EW-1:0] exp_val(input logic [EW-1:0] v);
`ifdef SA_DRAIN_SAT8_EN
    if ($signed(v) > 16'sd127) return 16'h007F;
    if ($signed(v) < -16'sd128) return 16'hFF80;
`endif
    return v;
  endfunction

  function automatic beat_t obs();
    beat_t b;
    b.data = out_data;
    b.mat  = out_mat;
    b.row  = out_row;
    b.col  = out_col;
    b.last = out_last;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pattern();
    for (int k = 0; k < NE; k++) begin
      res1_flat[k*EW +: EW] = EW'(k);
      res2_flat[k*EW +: EW] = EW'(100 + k);
    end
  endtask

  // Push the model of the job, then pulse done for one capture edge.
  task automatic start_job();
    beat_t b;
    int    e;
    for (int i = 0; i < 2*NE; i++) begin
      e      = i % NE;
      b.mat  = (i >= NE);
      b.row  = RW'(e / N);
      b.col  = RW'(e % N);
      b.last = (i == 2*NE - 1);
      b.data = exp_val(b.mat ? res2_flat[e*EW +: EW] : res1_flat[e*EW +: EW]);
      q.push_back(b);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    done      = 1'b0;
    out_ready = 1'b0;
    res1_flat = '0;
    res2_flat = '0;
    tick();
    tick();
    checks++;
    if ({out_valid, out_last, acc_clear, busy, overrun} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {out_valid, out_last, acc_clear, busy, overrun});
    end
    checks++;
    if ({out_data, out_mat, out_row, out_col} !== '0) begin
      failures++;
      $display("FAIL reset_data: got %h/%b/%0d/%0d want 0",
               out_data, out_mat, out_row, out_col);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy got %b want 0", busy);
    end
  endtask

  task automatic test_stream();
    beat_t exp;
    int    cyc;
    int    clr;
    load_pattern();
    q.delete();
    start_job();
    res1_flat = ~res1_flat;
    res2_flat = ~res2_flat;
    out_ready = 1'b1;
    cyc = 0;
    while (q.size() > 0 && cyc < 200) begin
      if (out_valid) begin
        exp = q.pop_front();
        checks++;
        if (obs() !== exp) begin
          failures++;
          $display("FAIL stream_beat: got %h want %h", obs(), exp);
        end
      end
      tick();
      cyc++;
    end
    clr = 0;
    while (busy && cyc < 200) begin
      if (acc_clear) clr++;
      if (out_valid) begin
        failures++;
        $display("FAIL stream_extra_valid: got 1 want 0");
      end
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 2*NE + 1) begin
      failures++;
      $display("FAIL stream_latency: got %0d want %0d", cyc, 2*NE + 1);
    end
    checks++;
    if (clr !== 1) begin
      failures++;
      $display("FAIL stream_acc_clear: got %0d cycles want 1", clr);
    end
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL stream_overrun: got %b want 0", overrun);
    end
  endtask

  task automatic test_stall();
    logic  pat [4];
    beat_t exp;
    beat_t held;
    logic  hold;
    int    cyc;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    load_pattern();
    q.delete();
    start_job();
    hold = 1'b0;
    cyc  = 0;
    while (q.size() > 0 && cyc < 300) begin
      out_ready = pat[cyc % 4];
      if (hold) begin
        checks++;
        if (obs() !== held) begin
          failures++;
          $display("FAIL stall_stable: got %h want %h", obs(), held);
        end
        hold = 1'b0;
      end
      if (out_valid) begin
        if (out_ready) begin
          exp = q.pop_front();
          checks++;
          if (obs() !== exp) begin
            failures++;
            $display("FAIL stall_beat: got %h want %h", obs(), exp);
          end
        end else begin
          held = obs();
          hold = 1'b1;
        end
      end
      tick();
      cyc++;
    end
    checks++;
    if (q.size() !== 0) begin
      failures++;
      $display("FAIL stall_timeout: left %0d want 0", q.size());
    end
    out_ready = 1'b1;
    while (busy && cyc < 400) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_overrun();
    beat_t exp;
    int    n;
    int    cyc;
    load_pattern();
    q.delete();
    start_job();
    out_ready = 1'b1;
    n   = 0;
    cyc = 0;
    while (q.size() > 0 && cyc < 200) begin
      done = (n == 5);
      if (n == 5) res1_flat = '1;
      if (out_valid) begin
        exp = q.pop_front();
        checks++;
        if (obs() !== exp) begin
          failures++;
          $display("FAIL overrun_beat: got %h want %h", obs(), exp);
        end
        n++;
      end
      tick();
      cyc++;
    end
    done = 1'b0;
    checks++;
    if (n !== 2*NE) begin
      failures++;
      $display("FAIL overrun_count: got %0d want %0d", n, 2*NE);
    end
    checks++;
    if (acc_clear !== 1'b1) begin
      failures++;
      $display("FAIL overrun_clear_state: got %b want 1", acc_clear);
    end
    // done while leaving CLEAR must not start a new job
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      failures++;
      $display("FAIL clear_done_ignored: got %b want 00", {busy, out_valid});
    end
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky: got %b want 1", overrun);
    end
  endtask

  task automatic test_reset_mid();
    beat_t exp;
    int    n;
    int    cyc;
    load_pattern();
    q.delete();
    start_job();
    out_ready = 1'b1;
    n = 0;
    while (n < 10) begin
      if (out_valid) begin
        exp = q.pop_front();
        checks++;
        if (obs() !== exp) begin
          failures++;
          $display("FAIL resetmid_pre: got %h want %h", obs(), exp);
        end
      end
      n++;
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({busy, out_valid, overrun} !== 3'b000) begin
      failures++;
      $display("FAIL resetmid_state: got %b want 000", {busy, out_valid, overrun});
    end
    q.delete();
    start_job();
    checks++;
    if (obs() !== q[0]) begin
      failures++;
      $display("FAIL resetmid_restart: got %h want %h", obs(), q[0]);
    end
    cyc = 0;
    while (q.size() > 0 && cyc < 200) begin
      if (out_valid) begin
        exp = q.pop_front();
        checks++;
        if (obs() !== exp) begin
          failures++;
          $display("FAIL resetmid_beat: got %h want %h", obs(), exp);
        end
      end
      tick();
      cyc++;
    end
    while (busy && cyc < 300) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_sat();
    logic [EW-1:0] want [3];
    logic [EW-1:0] got  [3];
    beat_t         exp;
    int            n;
    int            cyc;
`ifdef SA_DRAIN_SAT8_EN
    want = '{16'h007F, 16'hFF80, 16'h0045};
`else
    want = '{16'h0200, 16'hFE00, 16'h0045};
`endif
    load_pattern();
    res1_flat[0*EW +: EW] = 16'h0200;
    res1_flat[1*EW +: EW] = 16'hFE00;
    res1_flat[2*EW +: EW] = 16'h0045;
    q.delete();
    start_job();
    out_ready = 1'b1;
    n   = 0;
    cyc = 0;
    while (q.size() > 0 && cyc < 200) begin
      if (out_valid) begin
        if (n < 3) got[n] = out_data;
        exp = q.pop_front();
        checks++;
        if (obs() !== exp) begin
          failures++;
          $display("FAIL sat_beat: got %h want %h", obs(), exp);
        end
        n++;
      end
      tick();
      cyc++;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        failures++;
        $display("FAIL sat_value%0d: got %h want %h", i, got[i], want[i]);
      end
    end
    while (busy && cyc < 300) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_overrun();
    test_reset_mid();
    test_sat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
